// File: rtl/l2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_pkg
// Description : Shared types and constants for the L2 line port. Holds the
//               access state encoding, the data word width and a helper that
//               derives the byte-offset width of a cache line.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_WAIT = 3'd1,
        WR_BEAT = 3'd2,
        WR_DONE = 3'd3,
        RD_WAIT = 3'd4,
        RD_BEAT = 3'd5,
        RD_ACK  = 3'd6
    } l2_state_t;

    // Number of low address bits covered by one line (word offset + byte offset).
    function automatic int l2_offset_bits(input int words_per_line);
        return $clog2(words_per_line) + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_word_ram.sv
`default_nettype none
// ============================================================================
// Module      : l2_word_ram
// Description : Synchronous single-port word RAM. One access per cycle; a
//               write takes precedence over a read. Read data is registered
//               and holds its value when no read is issued.
// Ports       : clk   - clock
//               we    - write enable
//               re    - read enable
//               addr  - word address
//               wdata - write data
//               rdata - registered read data (valid the cycle after re)
// Revision    : 1.0 - initial release
// ============================================================================
module l2_word_ram #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end else if (re) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/l2_line_port.sv
`default_nettype none
// ============================================================================
// Module      : l2_line_port
// Description : Line-granular backing store behind the L1 cache controller.
//               Serves writebacks (write_l2 / write_done) and line fills
//               (fill_req / l2_ack / read_l2) with a fixed access latency
//               followed by one 32-bit word per cycle.
//               Optional feature macro: L2_PERF_CNT_EN adds the wb_count and
//               fill_count performance counters.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               write_l2        - writeback request (level)
//               fill_req        - fill request (level)
//               read_l2         - pulse: filled line consumed
//               addr            - byte address of the line
//               wdata_line      - line to write back, word 0 in LSBs
//               write_done      - pulse: writeback complete
//               l2_ack          - level: rdata_line valid until read_l2
//               rdata_line      - filled line, word 0 in LSBs
//               busy            - access in progress
//               wb_count        - writebacks completed (L2_PERF_CNT_EN)
//               fill_count      - fills consumed (L2_PERF_CNT_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module l2_line_port
    import l2_pkg::*;
#(
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_WORDS      = 4096,
    parameter int MEM_LATENCY    = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             write_l2,
    input  logic                             fill_req,
    input  logic                             read_l2,
    input  logic [31:0]                      addr,
    input  logic [WORD_W*WORDS_PER_LINE-1:0] wdata_line,
    output logic                             write_done,
    output logic                             l2_ack,
    output logic [WORD_W*WORDS_PER_LINE-1:0] rdata_line,
    output logic                             busy
`ifdef L2_PERF_CNT_EN
    ,
    output logic [31:0]                      wb_count,
    output logic [31:0]                      fill_count
`endif
);

    localparam int OFFSET_BITS = l2_offset_bits(WORDS_PER_LINE);
    localparam int c_ADDR_W    = $clog2(MEM_WORDS);
    localparam int c_BEAT_W    = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int c_LAT_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(WORDS_PER_LINE - 1);
    localparam logic [c_LAT_W-1:0]  c_LAT_LOAD  = c_LAT_W'(MEM_LATENCY - 1);
    localparam logic [c_ADDR_W-1:0] c_LINE_MASK = ~c_ADDR_W'((1 << (OFFSET_BITS - 2)) - 1);

    l2_state_t           r_state;
    logic [c_LAT_W-1:0]  r_lat;
    logic [c_BEAT_W-1:0] r_beat;
    logic [c_ADDR_W-1:0] r_base;
    logic [WORD_W-1:0]   r_wdata [WORDS_PER_LINE];
    logic [WORD_W-1:0]   r_rdata [WORDS_PER_LINE];
    logic                r_write_done;
    logic                r_l2_ack;

    logic [c_ADDR_W-1:0] w_line_base;
    logic [c_BEAT_W-1:0] w_ram_beat;
    logic [c_ADDR_W-1:0] w_ram_addr;
    logic                w_ram_we;
    logic                w_ram_re;
    logic [WORD_W-1:0]   w_ram_rdata;
    logic                w_unused_addr;

    // Word index of the line base; bits above the RAM depth alias (wrap).
    assign w_line_base   = addr[c_ADDR_W+1:2] & c_LINE_MASK;
    assign w_unused_addr = ^addr;

    // The RAM read is registered, so reads run one beat ahead of capture:
    // word 0 is fetched in the last wait cycle, word b+1 while word b lands.
    always_comb begin
        w_ram_beat = r_beat;
        if (r_state == RD_WAIT) begin
            w_ram_beat = '0;
        end else if (r_state == RD_BEAT) begin
            w_ram_beat = r_beat + c_BEAT_W'(1);
        end
    end

    assign w_ram_we   = (r_state == WR_BEAT);
    assign w_ram_re   = ((r_state == RD_WAIT) && (r_lat == '0)) ||
                        ((r_state == RD_BEAT) && (r_beat != c_LAST_BEAT));
    assign w_ram_addr = r_base + c_ADDR_W'(w_ram_beat);

    l2_word_ram #(
        .DEPTH (MEM_WORDS),
        .WIDTH (WORD_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .re    (w_ram_re),
        .addr  (w_ram_addr),
        .wdata (r_wdata[r_beat]),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lat        <= '0;
            r_beat       <= '0;
            r_base       <= '0;
            r_write_done <= 1'b0;
            r_l2_ack     <= 1'b0;
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                r_wdata[i] <= '0;
                r_rdata[i] <= '0;
            end
        end else begin
            r_write_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (write_l2) begin
                        r_base <= w_line_base;
                        for (int i = 0; i < WORDS_PER_LINE; i++) begin
                            r_wdata[i] <= wdata_line[i*WORD_W +: WORD_W];
                        end
                        r_lat   <= c_LAT_LOAD;
                        r_state <= WR_WAIT;
                    end else if (fill_req) begin
                        r_base  <= w_line_base;
                        r_lat   <= c_LAT_LOAD;
                        r_state <= RD_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (r_lat == '0) begin
                        r_beat  <= '0;
                        r_state <= WR_BEAT;
                    end else begin
                        r_lat <= r_lat - c_LAT_W'(1);
                    end
                end
                WR_BEAT: begin
                    if (r_beat == c_LAST_BEAT) begin
                        r_write_done <= 1'b1;
                        r_state      <= WR_DONE;
                    end else begin
                        r_beat <= r_beat + c_BEAT_W'(1);
                    end
                end
                WR_DONE: begin
                    r_state <= IDLE;
                end
                RD_WAIT: begin
                    if (r_lat == '0) begin
                        r_beat  <= '0;
                        r_state <= RD_BEAT;
                    end else begin
                        r_lat <= r_lat - c_LAT_W'(1);
                    end
                end
                RD_BEAT: begin
                    r_rdata[r_beat] <= w_ram_rdata;
                    if (r_beat == c_LAST_BEAT) begin
                        r_l2_ack <= 1'b1;
                        r_state  <= RD_ACK;
                    end else begin
                        r_beat <= r_beat + c_BEAT_W'(1);
                    end
                end
                RD_ACK: begin
                    if (read_l2) begin
                        r_l2_ack <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_pack
            assign rdata_line[g*WORD_W +: WORD_W] = r_rdata[g];
        end
    endgenerate

    assign write_done = r_write_done;
    assign l2_ack     = r_l2_ack;
    assign busy       = (r_state != IDLE);

`ifdef L2_PERF_CNT_EN
    logic [31:0] r_wb_count;
    logic [31:0] r_fill_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_count   <= '0;
            r_fill_count <= '0;
        end else begin
            if (r_state == WR_DONE) begin
                r_wb_count <= r_wb_count + 32'd1;
            end
            if ((r_state == RD_ACK) && read_l2) begin
                r_fill_count <= r_fill_count + 32'd1;
            end
        end
    end

    assign wb_count   = r_wb_count;
    assign fill_count = r_fill_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_line_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_line_port
// Description : Directed self-checking bench for l2_line_port (default
//               parameters: 4 words/line, 4096 words, latency 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_line_port;

    logic         clk = 1'b0;
    logic         reset;
    logic         write_l2;
    logic         fill_req;
    logic         read_l2;
    logic [31:0]  addr;
    logic [127:0] wdata_line;
    logic         write_done;
    logic         l2_ack;
    logic [127:0] rdata_line;
    logic         busy;
`ifdef L2_PERF_CNT_EN
    logic [31:0]  wb_count;
    logic [31:0]  fill_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] D1 = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] D2 = 128'h0000000d_0000000c_0000000b_0000000a;
    localparam logic [127:0] D3 = 128'hcafef00d_12345678_deadbeef_a5a55a5a;

    l2_line_port dut (
        .clk        (clk),
        .reset      (reset),
        .write_l2   (write_l2),
        .fill_req   (fill_req),
        .read_l2    (read_l2),
        .addr       (addr),
        .wdata_line (wdata_line),
        .write_done (write_done),
        .l2_ack     (l2_ack),
        .rdata_line (rdata_line),
        .busy       (busy)
`ifdef L2_PERF_CNT_EN
        ,
        .wb_count   (wb_count),
        .fill_count (fill_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Writeback with address/data perturbed after acceptance.
    task automatic do_write(input logic [31:0] a, input logic [127:0] d);
        addr       = a;
        wdata_line = d;
        write_l2   = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 1) begin
                addr       = a ^ 32'h0000_0010;
                wdata_line = ~d;
            end
            chk("wr_busy", {127'd0, busy}, 128'd1);
            chk("wr_done_timing", {127'd0, write_done}, {127'd0, (t == 8)});
        end
        write_l2 = 1'b0;
        tick();
        chk("wr_done_pulse_end", {127'd0, write_done}, 128'd0);
        chk("wr_idle_busy", {127'd0, busy}, 128'd0);
    endtask

    // Fill with a stray read_l2 during the wait phase and `hold` cycles of ack.
    task automatic do_fill(input logic [31:0] a, input logic [127:0] exp, input int hold);
        addr     = a;
        fill_req = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            read_l2 = (t == 2);
            chk("rd_busy", {127'd0, busy}, 128'd1);
            chk("rd_ack_timing", {127'd0, l2_ack}, {127'd0, (t == 8)});
        end
        chk("rd_data", rdata_line, exp);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("rd_ack_hold", {127'd0, l2_ack}, 128'd1);
            chk("rd_data_hold", rdata_line, exp);
        end
        read_l2  = 1'b1;
        fill_req = 1'b0;
        tick();
        read_l2 = 1'b0;
        chk("rd_ack_drop", {127'd0, l2_ack}, 128'd0);
        chk("rd_idle_busy", {127'd0, busy}, 128'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        write_l2   = 1'b0;
        fill_req   = 1'b0;
        read_l2    = 1'b0;
        addr       = '0;
        wdata_line = '0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("rst_write_done", {127'd0, write_done}, 128'd0);
        chk("rst_l2_ack", {127'd0, l2_ack}, 128'd0);
        chk("rst_rdata", rdata_line, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
`ifdef L2_PERF_CNT_EN
        chk("rst_wb_count", {96'd0, wb_count}, 128'd0);
        chk("rst_fill_count", {96'd0, fill_count}, 128'd0);
`endif

        // Basic writeback then fill of the same line at a non-base address.
        do_write(32'h0000_0840, D1);
        do_fill(32'h0000_0844, D1, 5);

        // Simultaneous requests: writeback first, fill starts after IDLE cycle.
        addr       = 32'h0000_0100;
        wdata_line = D2;
        write_l2   = 1'b1;
        fill_req   = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk("prio_wr_done", {127'd0, write_done}, {127'd0, (t == 8)});
            chk("prio_no_ack", {127'd0, l2_ack}, 128'd0);
        end
        write_l2 = 1'b0;
        tick();
        chk("prio_gap_done", {127'd0, write_done}, 128'd0);
        chk("prio_gap_idle", {127'd0, busy}, 128'd0);
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk("prio_rd_busy", {127'd0, busy}, 128'd1);
            chk("prio_rd_ack", {127'd0, l2_ack}, {127'd0, (t == 8)});
        end
        chk("prio_rd_data", rdata_line, D2);
        read_l2  = 1'b1;
        fill_req = 1'b0;
        tick();
        read_l2 = 1'b0;
        chk("prio_ack_drop", {127'd0, l2_ack}, 128'd0);

        // Reset in the middle of RD_BEAT aborts the fill.
        addr     = 32'h0000_0840;
        fill_req = 1'b1;
        repeat (5) tick();
        chk("mid_busy", {127'd0, busy}, 128'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_busy", {127'd0, busy}, 128'd0);
        chk("mid_rst_ack", {127'd0, l2_ack}, 128'd0);
        chk("mid_rst_done", {127'd0, write_done}, 128'd0);
        chk("mid_rst_rdata", rdata_line, 128'd0);
        reset = 1'b0;
        do_fill(32'h0000_0840, D1, 0);

        // Address above RAM depth aliases back onto word 0x210.
        do_fill(32'h0000_4840, D1, 1);

        // Last line of the RAM plus two more writebacks.
        do_write(32'h0000_3FF0, D3);
        do_write(32'h0000_0200, D2);
        do_write(32'h0000_0300, ~D1);
`ifdef L2_PERF_CNT_EN
        chk("perf_wb_count", {96'd0, wb_count}, 128'd3);
        chk("perf_fill_count", {96'd0, fill_count}, 128'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("perf_rst_wb", {96'd0, wb_count}, 128'd0);
        chk("perf_rst_fill", {96'd0, fill_count}, 128'd0);
`endif
        do_fill(32'h0000_3FFC, D3, 0);
        do_fill(32'h0000_0308, ~D1, 0);
        do_fill(32'h0000_0100, D2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
